// File: rtl/intm_rs_age_pkg.sv
// intm_rs_age_pkg
// Shared configuration for the age-ordered INTM reservation station:
// default geometry, the issue-port enumeration and the age-row type.
// No ports (package).
package intm_rs_age_pkg;

  localparam int INTMRS_DEPTH     = 8;
  localparam int INTMRS_ID_WIDTH  = 2;
  localparam int INTMRS_CDB_WIDTH = 2;
  localparam int INTMRS_NUM_FU    = 2;
  localparam int INTMRS_PRF_IDX   = 6;
  localparam int INTMRS_ROB_IDX   = 5;
  localparam int INTMRS_OPC_W     = 4;
  localparam int INTMRS_ARCH_W    = 5;
  localparam int INTMRS_FU_SEL_W  = (INTMRS_NUM_FU > 1) ? $clog2(INTMRS_NUM_FU) : 1;

  // Issue port numbering: 0 = multiplier, 1 = divider.
  typedef enum logic [INTMRS_FU_SEL_W-1:0] {
    FU_MUL = 0,
    FU_DIV = 1
  } intm_fu_e;

  // One row of the age matrix: bit j set means entry j is older.
  typedef logic [INTMRS_DEPTH-1:0] intm_age_row_t;

endpackage

// File: rtl/intm_rs_age_if.sv
// intm_rs_age_if
// Dispatch, CDB wakeup, FU-ready, issue and occupancy signals of the
// reservation station, bundled as one interface.
//   master : dispatch/backend side (drives ds_*, cdb_*, fu_ready, flush)
//   slave  : reservation station (drives ds_ready, iss_*, free_count)
interface intm_rs_age_if
  import intm_rs_age_pkg::*;
#(
  parameter int DEPTH     = INTMRS_DEPTH,
  parameter int ID_WIDTH  = INTMRS_ID_WIDTH,
  parameter int CDB_WIDTH = INTMRS_CDB_WIDTH,
  parameter int NUM_FU    = INTMRS_NUM_FU,
  parameter int PRF_IDX   = INTMRS_PRF_IDX,
  parameter int ROB_IDX   = INTMRS_ROB_IDX,
  parameter int OPC_W     = INTMRS_OPC_W
) ();

  localparam int FSW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;

  logic                                 flush;
  logic [ID_WIDTH-1:0]                  ds_valid;
  logic                                 ds_ready;
  logic [ID_WIDTH-1:0][ROB_IDX-1:0]     ds_rob_id;
  logic [ID_WIDTH-1:0][PRF_IDX-1:0]     ds_rs1_phy;
  logic [ID_WIDTH-1:0][PRF_IDX-1:0]     ds_rs2_phy;
  logic [ID_WIDTH-1:0][PRF_IDX-1:0]     ds_rd_phy;
  logic [ID_WIDTH-1:0]                  ds_rs1_valid;
  logic [ID_WIDTH-1:0]                  ds_rs2_valid;
  logic [ID_WIDTH-1:0][4:0]             ds_rd_arch;
  logic [ID_WIDTH-1:0][OPC_W-1:0]       ds_opcode;
  logic [ID_WIDTH-1:0][FSW-1:0]         ds_fu_sel;
  logic [CDB_WIDTH-1:0]                 cdb_valid;
  logic [CDB_WIDTH-1:0][PRF_IDX-1:0]    cdb_rd_phy;
  logic [NUM_FU-1:0]                    fu_ready;
  logic [NUM_FU-1:0]                    iss_valid;
  logic [NUM_FU-1:0][ROB_IDX-1:0]       iss_rob_id;
  logic [NUM_FU-1:0][PRF_IDX-1:0]       iss_rs1_phy;
  logic [NUM_FU-1:0][PRF_IDX-1:0]       iss_rs2_phy;
  logic [NUM_FU-1:0][PRF_IDX-1:0]       iss_rd_phy;
  logic [NUM_FU-1:0][4:0]               iss_rd_arch;
  logic [NUM_FU-1:0][OPC_W-1:0]         iss_opcode;
  logic [CW-1:0]                        free_count;

  modport master (
    output flush, ds_valid, ds_rob_id, ds_rs1_phy, ds_rs2_phy, ds_rd_phy,
           ds_rs1_valid, ds_rs2_valid, ds_rd_arch, ds_opcode, ds_fu_sel,
           cdb_valid, cdb_rd_phy, fu_ready,
    input  ds_ready, iss_valid, iss_rob_id, iss_rs1_phy, iss_rs2_phy,
           iss_rd_phy, iss_rd_arch, iss_opcode, free_count
  );

  modport slave (
    input  flush, ds_valid, ds_rob_id, ds_rs1_phy, ds_rs2_phy, ds_rd_phy,
           ds_rs1_valid, ds_rs2_valid, ds_rd_arch, ds_opcode, ds_fu_sel,
           cdb_valid, cdb_rd_phy, fu_ready,
    output ds_ready, iss_valid, iss_rob_id, iss_rs1_phy, iss_rs2_phy,
           iss_rd_phy, iss_rd_arch, iss_opcode, free_count
  );

endinterface

// File: rtl/intm_rs_age_picker.sv
// intm_rs_age_picker
// Oldest-first arbiter over an age matrix.
//   en    : grant enable (FU ready and no flush)
//   req   : per-entry request vector
//   older : older[i][j]=1 when entry j is older than entry i
//   gnt   : one-hot grant of the oldest requester (zero if none / !en)
module intm_rs_age_picker #(
  parameter int DEPTH = 8
) (
  input  logic                        en,
  input  logic [DEPTH-1:0]            req,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            gnt
);

  // Age order is total among valid entries, so exactly one requester has
  // no older requester.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gnt[i] = en & req[i] & ~|(req & older[i]);
    end
  end

endmodule

// File: rtl/intm_rs_age.sv
// intm_rs_age
// Age-ordered INTM (mul/div) reservation station. Accepts up to ID_WIDTH
// uops per cycle, wakes operands from CDB tags, and issues the oldest ready
// entry on each of NUM_FU ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : intm_rs_age_if.slave (dispatch, CDB, FU ready, flush,
//                issue payloads, ds_ready, free_count)
module intm_rs_age
  import intm_rs_age_pkg::*;
#(
  parameter int DEPTH     = INTMRS_DEPTH,
  parameter int ID_WIDTH  = INTMRS_ID_WIDTH,
  parameter int CDB_WIDTH = INTMRS_CDB_WIDTH,
  parameter int NUM_FU    = INTMRS_NUM_FU,
  parameter int PRF_IDX   = INTMRS_PRF_IDX,
  parameter int ROB_IDX   = INTMRS_ROB_IDX,
  parameter int OPC_W     = INTMRS_OPC_W
) (
  input logic          clk,
  input logic          rst_n,
  intm_rs_age_if.slave bus
);

  localparam int FSW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int LW  = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ROB_IDX-1:0] rob_id;
    logic [PRF_IDX-1:0] rs1_phy;
    logic [PRF_IDX-1:0] rs2_phy;
    logic [PRF_IDX-1:0] rd_phy;
    logic [4:0]         rd_arch;
    logic [OPC_W-1:0]   opcode;
  } payload_t;

  logic [DEPTH-1:0]            valid_q, rs1_rdy_q, rs2_rdy_q;
  logic [DEPTH-1:0][DEPTH-1:0] older_q;
  logic [DEPTH-1:0][FSW-1:0]   fu_sel_q;
  payload_t [DEPTH-1:0]        pay_q;

  logic [CW-1:0]               free_cnt;
  logic                        ds_ready_int;
  logic [DEPTH-1:0]            alloc_any;
  logic [DEPTH-1:0][LW-1:0]    alloc_lane;
  logic [DEPTH-1:0][DEPTH-1:0] alloc_row;
  logic [DEPTH-1:0]            req [NUM_FU];
  logic [DEPTH-1:0]            gnt [NUM_FU];
  logic [DEPTH-1:0]            dealloc;
  payload_t [NUM_FU-1:0]       iss_pay;

  function automatic logic cdb_hit(
    input logic [PRF_IDX-1:0]                 tag,
    input logic [CDB_WIDTH-1:0]               cv,
    input logic [CDB_WIDTH-1:0][PRF_IDX-1:0]  ct
  );
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++) begin
      if (cv[c] && (ct[c] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Occupancy from registered state only
  always_comb begin
    free_cnt = CW'(DEPTH);
    for (int i = 0; i < DEPTH; i++) free_cnt = free_cnt - CW'(valid_q[i]);
  end
  assign ds_ready_int   = (free_cnt >= CW'(ID_WIDTH));
  assign bus.ds_ready   = ds_ready_int;
  assign bus.free_count = free_cnt;

  // Allocation: each lane takes the lowest free slot not claimed by lower
  // lanes. Its age row is everything that survives this edge plus lower
  // lanes' new entries.
  always_comb begin
    logic [DEPTH-1:0] taken;
    logic             found;
    taken      = valid_q;
    alloc_any  = '0;
    alloc_lane = '0;
    alloc_row  = '0;
    for (int w = 0; w < ID_WIDTH; w++) begin
      found = 1'b0;
      if (bus.ds_valid[w] && ds_ready_int) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && !taken[i]) begin
            found         = 1'b1;
            alloc_any[i]  = 1'b1;
            alloc_lane[i] = LW'(w);
            alloc_row[i]  = taken & ~dealloc;
            taken[i]      = 1'b1;
          end
        end
      end
    end
  end

  // Request and oldest-first grant per FU port
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        req[f][i] = valid_q[i] & rs1_rdy_q[i] & rs2_rdy_q[i] &
                    (fu_sel_q[i] == FSW'(f));
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_pick
    intm_rs_age_picker #(.DEPTH(DEPTH)) u_pick (
      .en    (bus.fu_ready[f] & ~bus.flush),
      .req   (req[f]),
      .older (older_q),
      .gnt   (gnt[f])
    );
  end

  // Issue: one-hot payload mux per port
  always_comb begin
    dealloc = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      iss_pay[f] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt[f][i]) iss_pay[f] = payload_t'(iss_pay[f] | pay_q[i]);
      end
      dealloc              = dealloc | gnt[f];
      bus.iss_valid[f]     = |gnt[f];
      bus.iss_rob_id[f]    = iss_pay[f].rob_id;
      bus.iss_rs1_phy[f]   = iss_pay[f].rs1_phy;
      bus.iss_rs2_phy[f]   = iss_pay[f].rs2_phy;
      bus.iss_rd_phy[f]    = iss_pay[f].rd_phy;
      bus.iss_rd_arch[f]   = iss_pay[f].rd_arch;
      bus.iss_opcode[f]    = iss_pay[f].opcode;
    end
  end

  // Entry control state: flush > allocate > issue/wakeup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      older_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      older_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_any[i]) begin
          valid_q[i]   <= 1'b1;
          rs1_rdy_q[i] <= bus.ds_rs1_valid[alloc_lane[i]] |
                          cdb_hit(bus.ds_rs1_phy[alloc_lane[i]], bus.cdb_valid, bus.cdb_rd_phy);
          rs2_rdy_q[i] <= bus.ds_rs2_valid[alloc_lane[i]] |
                          cdb_hit(bus.ds_rs2_phy[alloc_lane[i]], bus.cdb_valid, bus.cdb_rd_phy);
          older_q[i]   <= alloc_row[i];
        end else begin
          if (dealloc[i]) valid_q[i] <= 1'b0;
          if (cdb_hit(pay_q[i].rs1_phy, bus.cdb_valid, bus.cdb_rd_phy)) rs1_rdy_q[i] <= 1'b1;
          if (cdb_hit(pay_q[i].rs2_phy, bus.cdb_valid, bus.cdb_rd_phy)) rs2_rdy_q[i] <= 1'b1;
          older_q[i] <= older_q[i] & ~dealloc;
        end
      end
    end
  end

  // Entry payload (no reset; qualified by valid_q)
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_any[i]) begin
        fu_sel_q[i]      <= bus.ds_fu_sel[alloc_lane[i]];
        pay_q[i].rob_id  <= bus.ds_rob_id[alloc_lane[i]];
        pay_q[i].rs1_phy <= bus.ds_rs1_phy[alloc_lane[i]];
        pay_q[i].rs2_phy <= bus.ds_rs2_phy[alloc_lane[i]];
        pay_q[i].rd_phy  <= bus.ds_rd_phy[alloc_lane[i]];
        pay_q[i].rd_arch <= bus.ds_rd_arch[alloc_lane[i]];
        pay_q[i].opcode  <= bus.ds_opcode[alloc_lane[i]];
      end
    end
  end

endmodule

// File: tb/tb_intm_rs_age.sv
// tb_intm_rs_age
// Directed self-checking bench for intm_rs_age.
module tb_intm_rs_age;
  import intm_rs_age_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  intm_rs_age_if bus ();

  intm_rs_age u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.flush = 1'b0; bus.ds_valid = '0; bus.ds_rob_id = '0;
    bus.ds_rs1_phy = '0; bus.ds_rs2_phy = '0; bus.ds_rd_phy = '0;
    bus.ds_rs1_valid = '0; bus.ds_rs2_valid = '0; bus.ds_rd_arch = '0;
    bus.ds_opcode = '0; bus.ds_fu_sel = '0; bus.cdb_valid = '0;
    bus.cdb_rd_phy = '0; bus.fu_ready = '0;
  endtask

  // Payload derived from rob: rd_phy = rob+8, rd_arch = rob^31, opcode = rob&15
  task automatic push(input int lane, input int rob, input int rs1, input bit rs1v,
                      input int rs2, input bit rs2v, input int fu);
    bus.ds_valid[lane]     = 1'b1;
    bus.ds_rob_id[lane]    = 5'(rob);
    bus.ds_rs1_phy[lane]   = 6'(rs1);
    bus.ds_rs1_valid[lane] = rs1v;
    bus.ds_rs2_phy[lane]   = 6'(rs2);
    bus.ds_rs2_valid[lane] = rs2v;
    bus.ds_rd_phy[lane]    = 6'(rob + 8);
    bus.ds_rd_arch[lane]   = 5'(rob ^ 31);
    bus.ds_opcode[lane]    = 4'(rob & 15);
    bus.ds_fu_sel[lane]    = 1'(fu);
  endtask

  task automatic cdb(input int port, input int tag);
    bus.cdb_valid[port]  = 1'b1;
    bus.cdb_rd_phy[port] = 6'(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.ds_valid = '0; bus.cdb_valid = '0; bus.flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (bus.ds_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ds_ready: got %0b expected 1", bus.ds_ready); end
    n_checks++; if (bus.iss_valid !== 2'b00) begin n_fail++; $display("FAIL reset_iss_valid: got %b expected 00", bus.iss_valid); end
    n_checks++; if (bus.free_count !== 4'd8) begin n_fail++; $display("FAIL reset_free_count: got %0d expected 8", bus.free_count); end
    #9 rst_n = 1'b1;
  endtask

  task automatic test_two_push();
    bus.fu_ready = 2'b01;
    push(0, 1, 0, 1, 0, 1, FU_MUL);
    push(1, 2, 0, 1, 0, 1, FU_MUL);
    #1;
    n_checks++; if (bus.ds_ready !== 1'b1) begin n_fail++; $display("FAIL two_push_ready: got %0b expected 1", bus.ds_ready); end
    tick();
    n_checks++; if (bus.free_count !== 4'd6) begin n_fail++; $display("FAIL two_push_free6: got %0d expected 6", bus.free_count); end
    n_checks++; if (bus.iss_valid !== 2'b01 || bus.iss_rob_id[0] !== 5'd1) begin n_fail++; $display("FAIL two_push_issue1: got valid %b rob %0d expected 01 rob 1", bus.iss_valid, bus.iss_rob_id[0]); end
    tick();
    n_checks++; if (bus.free_count !== 4'd7) begin n_fail++; $display("FAIL two_push_free7: got %0d expected 7", bus.free_count); end
    n_checks++; if (bus.iss_valid !== 2'b01 || bus.iss_rob_id[0] !== 5'd2) begin n_fail++; $display("FAIL two_push_issue2: got valid %b rob %0d expected 01 rob 2", bus.iss_valid, bus.iss_rob_id[0]); end
    tick();
    n_checks++; if (bus.free_count !== 4'd8 || bus.iss_valid !== 2'b00) begin n_fail++; $display("FAIL two_push_drained: got free %0d valid %b expected 8 00", bus.free_count, bus.iss_valid); end
  endtask

  task automatic test_fill_wakeup();
    bus.fu_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      push(0, 10 + 2 * k, 12, 0, 0, 1, FU_MUL);
      push(1, 11 + 2 * k, 12, 0, 0, 1, FU_MUL);
      tick();
    end
    n_checks++; if (bus.free_count !== 4'd2 || bus.ds_ready !== 1'b1) begin n_fail++; $display("FAIL fill_six: got free %0d ready %0b expected 2 1", bus.free_count, bus.ds_ready); end
    push(0, 16, 12, 0, 0, 1, FU_MUL);
    tick();
    n_checks++; if (bus.free_count !== 4'd1 || bus.ds_ready !== 1'b0) begin n_fail++; $display("FAIL fill_seven: got free %0d ready %0b expected 1 0", bus.free_count, bus.ds_ready); end
    push(0, 17, 0, 1, 0, 1, FU_MUL);
    push(1, 18, 0, 1, 0, 1, FU_MUL);
    tick();
    n_checks++; if (bus.free_count !== 4'd1) begin n_fail++; $display("FAIL fill_drop_when_full: got free %0d expected 1", bus.free_count); end
    bus.fu_ready = 2'b01;
    #1;
    n_checks++; if (bus.iss_valid !== 2'b00) begin n_fail++; $display("FAIL fill_waiting: got %b expected 00", bus.iss_valid); end
    cdb(1, 12);
    #1;
    n_checks++; if (bus.iss_valid !== 2'b00) begin n_fail++; $display("FAIL fill_wake_cycle: got %b expected 00", bus.iss_valid); end
    tick();
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (bus.iss_valid[0] !== 1'b1 || bus.iss_rob_id[0] !== 5'(10 + k)) begin n_fail++; $display("FAIL fill_drain_%0d: got valid %b rob %0d expected 1 rob %0d", k, bus.iss_valid[0], bus.iss_rob_id[0], 10 + k); end
      tick();
    end
    n_checks++; if (bus.free_count !== 4'd8) begin n_fail++; $display("FAIL fill_empty: got %0d expected 8", bus.free_count); end
  endtask

  task automatic test_age_and_flush();
    bus.fu_ready = 2'b00;
    push(0, 20, 41, 0, 0, 1, FU_MUL);
    push(1, 21, 0, 1, 0, 1, FU_DIV);
    tick();
    push(0, 22, 41, 0, 0, 1, FU_MUL);
    push(1, 23, 40, 0, 0, 1, FU_MUL);
    tick();
    n_checks++; if (bus.free_count !== 4'd4) begin n_fail++; $display("FAIL age_fill4: got %0d expected 4", bus.free_count); end
    bus.fu_ready = 2'b10;
    #1;
    n_checks++; if (bus.iss_valid !== 2'b10 || bus.iss_rob_id[1] !== 5'd21) begin n_fail++; $display("FAIL age_free_idx1: got valid %b rob %0d expected 10 rob 21", bus.iss_valid, bus.iss_rob_id[1]); end
    tick();
    bus.fu_ready = 2'b00;
    push(0, 24, 40, 0, 0, 1, FU_MUL);
    tick();
    n_checks++; if (bus.free_count !== 4'd4) begin n_fail++; $display("FAIL age_realloc: got %0d expected 4", bus.free_count); end
    cdb(0, 40);
    tick();
    bus.fu_ready = 2'b01;
    #1;
    n_checks++; if (bus.iss_valid !== 2'b01 || bus.iss_rob_id[0] !== 5'd23) begin n_fail++; $display("FAIL age_oldest_first: got valid %b rob %0d expected 01 rob 23", bus.iss_valid, bus.iss_rob_id[0]); end
    tick();
    n_checks++; if (bus.iss_valid !== 2'b01 || bus.iss_rob_id[0] !== 5'd24) begin n_fail++; $display("FAIL age_second: got valid %b rob %0d expected 01 rob 24", bus.iss_valid, bus.iss_rob_id[0]); end
    tick();
    n_checks++; if (bus.iss_valid !== 2'b00 || bus.free_count !== 4'd6) begin n_fail++; $display("FAIL age_after: got valid %b free %0d expected 00 6", bus.iss_valid, bus.free_count); end
    push(0, 25, 41, 0, 0, 1, FU_MUL);
    push(1, 26, 41, 0, 0, 1, FU_MUL);
    tick();
    push(0, 27, 41, 0, 0, 1, FU_MUL);
    tick();
    n_checks++; if (bus.free_count !== 4'd3) begin n_fail++; $display("FAIL flush_five_valid: got %0d expected 3", bus.free_count); end
    bus.fu_ready = 2'b00;
    cdb(1, 41);
    tick();
    bus.fu_ready = 2'b11;
    bus.flush = 1'b1;
    push(0, 28, 0, 1, 0, 1, FU_MUL);
    #1;
    n_checks++; if (bus.iss_valid !== 2'b00) begin n_fail++; $display("FAIL flush_iss_valid: got %b expected 00", bus.iss_valid); end
    tick();
    n_checks++; if (bus.free_count !== 4'd8 || bus.iss_valid !== 2'b00 || bus.ds_ready !== 1'b1) begin n_fail++; $display("FAIL flush_cleared: got free %0d valid %b ready %0b expected 8 00 1", bus.free_count, bus.iss_valid, bus.ds_ready); end
  endtask

  task automatic test_async_reset();
    bus.fu_ready = 2'b00;
    push(0, 50, 0, 1, 0, 1, FU_MUL);
    push(1, 51, 0, 1, 0, 1, FU_MUL);
    tick();
    n_checks++; if (bus.free_count !== 4'd6) begin n_fail++; $display("FAIL arst_before: got %0d expected 6", bus.free_count); end
    bus.fu_ready = 2'b01;
    #1;
    n_checks++; if (bus.iss_valid !== 2'b01) begin n_fail++; $display("FAIL arst_pending_issue: got %b expected 01", bus.iss_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.free_count !== 4'd8 || bus.iss_valid !== 2'b00 || bus.ds_ready !== 1'b1) begin n_fail++; $display("FAIL arst_immediate: got free %0d valid %b ready %0b expected 8 00 1", bus.free_count, bus.iss_valid, bus.ds_ready); end
    #1 rst_n = 1'b1;
    tick();
    n_checks++; if (bus.free_count !== 4'd8) begin n_fail++; $display("FAIL arst_after_edge: got %0d expected 8", bus.free_count); end
  endtask

  task automatic test_dual_port();
    bus.fu_ready = 2'b00;
    push(0, 30, 3, 1, 9, 1, FU_MUL);
    push(1, 31, 5, 1, 4, 1, FU_DIV);
    tick();
    bus.fu_ready = 2'b11;
    #1;
    n_checks++; if (bus.iss_valid !== 2'b11) begin n_fail++; $display("FAIL dual_both_valid: got %b expected 11", bus.iss_valid); end
    n_checks++; if (bus.iss_rob_id[0] !== 5'd30 || bus.iss_rob_id[1] !== 5'd31) begin n_fail++; $display("FAIL dual_rob: got %0d %0d expected 30 31", bus.iss_rob_id[0], bus.iss_rob_id[1]); end
    n_checks++; if (bus.iss_rd_phy[1] !== 6'd39 || bus.iss_opcode[1] !== 4'd15 || bus.iss_rs2_phy[1] !== 6'd4) begin n_fail++; $display("FAIL dual_div_payload: got rd %0d opc %0d rs2 %0d expected 39 15 4", bus.iss_rd_phy[1], bus.iss_opcode[1], bus.iss_rs2_phy[1]); end
    n_checks++; if (bus.iss_rd_arch[0] !== 5'd1 || bus.iss_rs1_phy[0] !== 6'd3 || bus.iss_rs2_phy[0] !== 6'd9) begin n_fail++; $display("FAIL dual_mul_payload: got arch %0d rs1 %0d rs2 %0d expected 1 3 9", bus.iss_rd_arch[0], bus.iss_rs1_phy[0], bus.iss_rs2_phy[0]); end
    bus.fu_ready = 2'b01;
    #1;
    n_checks++; if (bus.iss_valid !== 2'b01) begin n_fail++; $display("FAIL dual_div_held: got %b expected 01", bus.iss_valid); end
    tick();
    n_checks++; if (bus.free_count !== 4'd7 || bus.iss_valid !== 2'b00) begin n_fail++; $display("FAIL dual_after_mul: got free %0d valid %b expected 7 00", bus.free_count, bus.iss_valid); end
    bus.fu_ready = 2'b10;
    #1;
    n_checks++; if (bus.iss_valid !== 2'b10 || bus.iss_rob_id[1] !== 5'd31) begin n_fail++; $display("FAIL dual_div_later: got valid %b rob %0d expected 10 rob 31", bus.iss_valid, bus.iss_rob_id[1]); end
    tick();
    n_checks++; if (bus.free_count !== 4'd8) begin n_fail++; $display("FAIL dual_empty: got %0d expected 8", bus.free_count); end
  endtask

  task automatic test_bypass();
    bus.fu_ready = 2'b01;
    push(0, 40, 0, 1, 20, 0, FU_MUL);
    push(1, 41, 0, 1, 21, 0, FU_MUL);
    cdb(0, 20);
    tick();
    n_checks++; if (bus.iss_valid !== 2'b01 || bus.iss_rob_id[0] !== 5'd40) begin n_fail++; $display("FAIL bypass_issue: got valid %b rob %0d expected 01 rob 40", bus.iss_valid, bus.iss_rob_id[0]); end
    tick();
    n_checks++; if (bus.iss_valid !== 2'b00 || bus.free_count !== 4'd7) begin n_fail++; $display("FAIL bypass_other_waits: got valid %b free %0d expected 00 7", bus.iss_valid, bus.free_count); end
    cdb(0, 21);
    tick();
    n_checks++; if (bus.iss_valid !== 2'b01 || bus.iss_rob_id[0] !== 5'd41) begin n_fail++; $display("FAIL bypass_late_wake: got valid %b rob %0d expected 01 rob 41", bus.iss_valid, bus.iss_rob_id[0]); end
    tick();
    n_checks++; if (bus.free_count !== 4'd8) begin n_fail++; $display("FAIL bypass_empty: got %0d expected 8", bus.free_count); end
  endtask

  initial begin
    test_reset();
    test_two_push();
    test_fill_wakeup();
    test_age_and_flush();
    test_async_reset();
    test_dual_port();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
